// File: rtl/mem_access_unit.sv
// mem_access_unit: registered MIPS32 MEM stage (ALU passthrough, big-endian loads/stores on req/ack bus, watchdog); optional MEM_ALIGN_CHECK_EN; ports: ex_* in, bus_* out/in, wb_* out, mem_err out
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [3:0]            ex_op,
  input  logic [31:0]           ex_wdata,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic                  ex_wr_en,
  input  logic [ADDR_W-1:0]     ex_mem_addr,
  input  logic [31:0]           ex_store_data,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic [31:0]           bus_rdata,
  input  logic                  bus_ack,
  output logic                  wb_valid,
  output logic [31:0]           wb_wdata,
  output logic [REG_ADDR_W-1:0] wb_waddr,
  output logic                  wb_wr_en,
  output logic                  mem_err
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_n;
  logic [3:0] op_q;
  logic [1:0] off_q, off;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic wr_en_q, fire, is_load, is_store, misal, tmo;
  logic [CW-1:0] cnt;
  logic [3:0] be_n;
  logic [31:0] wdata_n, ld_data;
  logic [15:0] half;
  logic [7:0] lb;
  assign off = ex_mem_addr[1:0];
  assign is_load = ex_op >= 4'd1 && ex_op <= 4'd5;
  assign is_store = ex_op >= 4'd6 && ex_op <= 4'd8;
`ifdef MEM_ALIGN_CHECK_EN
  assign misal = ((ex_op == 4'd3 || ex_op == 4'd4 || ex_op == 4'd7) && off[0]) ||
                 ((ex_op == 4'd5 || ex_op == 4'd8) && off != 2'b00);
`else
  assign misal = 1'b0;
`endif
  // Ack in the same cycle as the timeout takes priority (checked first below).
  assign tmo = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  assign be_n = ex_op == 4'd6 ? 4'b1000 >> off : ex_op == 4'd7 ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign wdata_n = ex_op == 4'd6 ? {4{ex_store_data[7:0]}} : ex_op == 4'd7 ? {2{ex_store_data[15:0]}} : ex_store_data;
  // Big-endian: byte offset 0 lives in bits [31:24].
  assign lb = 8'(bus_rdata >> {~off_q, 3'b000});
  assign half = off_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];
  assign ld_data = op_q == 4'd1 ? {{24{lb[7]}}, lb} :
                   op_q == 4'd2 ? {24'h0, lb} :
                   op_q == 4'd3 ? {{16{half[15]}}, half} :
                   op_q == 4'd4 ? {16'h0, half} : bus_rdata;
  always_comb begin
    ex_ready = state == IDLE;
    bus_req = state == ACCESS;
    fire = ex_valid & ex_ready;
    state_n = state == IDLE ? ((fire & (is_load | is_store) & ~misal) ? ACCESS : IDLE)
                            : ((bus_ack | tmo) ? IDLE : ACCESS);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q <= '0;
      off_q <= '0;
      waddr_q <= '0;
      wr_en_q <= 1'b0;
      cnt <= '0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
      wb_valid <= 1'b0;
      wb_wdata <= '0;
      wb_waddr <= '0;
      wb_wr_en <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      mem_err <= 1'b0;
      if (state == IDLE && fire) begin
        if (!(is_load | is_store)) begin
          wb_valid <= 1'b1;
          wb_wdata <= ex_wdata;
          wb_waddr <= ex_waddr;
          wb_wr_en <= ex_wr_en;
        end else if (misal) begin
          wb_valid <= 1'b1;
          wb_waddr <= ex_waddr;
          wb_wr_en <= 1'b0;
          mem_err <= 1'b1;
        end else begin
          op_q <= ex_op;
          off_q <= off;
          waddr_q <= ex_waddr;
          wr_en_q <= ex_wr_en & is_load;
          cnt <= '0;
          bus_we <= is_store;
          bus_addr <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
          bus_be <= is_store ? be_n : 4'b1111;
          bus_wdata <= wdata_n;
        end
      end else if (state == ACCESS) begin
        if (bus_ack) begin
          wb_valid <= 1'b1;
          wb_wdata <= ld_data;
          wb_waddr <= waddr_q;
          wb_wr_en <= wr_en_q;
        end else if (tmo) begin
          wb_valid <= 1'b1;
          wb_waddr <= waddr_q;
          wb_wr_en <= 1'b0;
          mem_err <= 1'b1;
        end else cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit with a lane-level reference model
module tb_mem_access_unit;
  logic clk, rst, ex_valid, ex_ready, ex_wr_en, bus_req, bus_we, bus_ack, wb_valid, wb_wr_en, mem_err;
  logic [3:0] ex_op, bus_be;
  logic [31:0] ex_wdata, ex_mem_addr, ex_store_data, bus_addr, bus_wdata, bus_rdata, wb_wdata;
  logic [4:0] ex_waddr, wb_waddr;
  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_wdata(ex_wdata), .ex_waddr(ex_waddr), .ex_wr_en(ex_wr_en), .ex_mem_addr(ex_mem_addr),
    .ex_store_data(ex_store_data), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .wb_valid(wb_valid), .wb_wdata(wb_wdata), .wb_waddr(wb_waddr), .wb_wr_en(wb_wr_en), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] model_load(logic [3:0] op, logic [1:0] off, logic [31:0] rd);
    logic [7:0] b [4];
    logic [15:0] h;
    int i;
    for (int k = 0; k < 4; k++) b[k] = rd[31-8*k -: 8];
    i = off[1] ? 2 : 0;
    h = {b[i], b[i+1]};
    case (op)
      4'd1: return {{24{b[off][7]}}, b[off]};
      4'd2: return {24'h0, b[off]};
      4'd3: return {{16{h[15]}}, h};
      4'd4: return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_be(logic [3:0] op, logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    if (op == 4'd6) begin
      be = 4'b0000;
      be[3 - int'(off)] = 1'b1;
    end else if (op == 4'd7) begin
      be = off[1] ? 4'b0011 : 4'b1100;
    end
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(logic [3:0] op, logic [31:0] sd);
    logic [31:0] w;
    for (int k = 0; k < 4; k++)
      w[8*k +: 8] = op == 4'd6 ? sd[7:0] : op == 4'd7 ? sd[8*(k%2) +: 8] : sd[8*k +: 8];
    return w;
  endfunction

  function automatic bit model_mis(logic [3:0] op, logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
    return ((op == 4'd3 || op == 4'd4 || op == 4'd7) && addr[0]) || ((op == 4'd5 || op == 4'd8) && addr[1:0] != 2'b00);
`else
    return addr[0] & 1'b0;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] op, input logic [31:0] wd, input logic [4:0] wa, input logic we,
                        input logic [31:0] addr, input logic [31:0] sd);
    ex_valid = 1'b1; ex_op = op; ex_wdata = wd; ex_waddr = wa; ex_wr_en = we; ex_mem_addr = addr; ex_store_data = sd;
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rd);
    bus_ack = 1'b1; bus_rdata = rd;
    tick();
    bus_ack = 1'b0; bus_rdata = $urandom;
  endtask

  task automatic test_reset;
    rst = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_wdata = '0; ex_waddr = '0; ex_wr_en = 1'b0;
    ex_mem_addr = '0; ex_store_data = '0; bus_rdata = '0; bus_ack = 1'b0;
    #13;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready got=%b exp=1", ex_ready); end
    checks++; if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== '0) begin errors++; $display("FAIL reset_bus got req=%b we=%b be=%b addr=%h wdata=%h exp=0", bus_req, bus_we, bus_be, bus_addr, bus_wdata); end
    checks++; if ({wb_valid, wb_wr_en, wb_waddr, wb_wdata, mem_err} !== '0) begin errors++; $display("FAIL reset_wb got v=%b we=%b a=%h d=%h err=%b exp=0", wb_valid, wb_wr_en, wb_waddr, wb_wdata, mem_err); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_alu;
    accept(4'd0, 32'h12345678, 5'd3, 1'b1, 32'h0, 32'h0);
    checks++; if ({wb_valid, wb_wdata, wb_waddr, wb_wr_en} !== {1'b1, 32'h12345678, 5'd3, 1'b1}) begin errors++; $display("FAIL alu_wb got v=%b d=%h a=%0d we=%b exp v=1 d=12345678 a=3 we=1", wb_valid, wb_wdata, wb_waddr, wb_wr_en); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL alu_no_req got=%b exp=0", bus_req); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_pulse got=%b exp=0", wb_valid); end
  endtask

  task automatic test_load_byte;
    for (int s = 0; s < 2; s++) begin
      logic [31:0] exp;
      exp = s == 0 ? 32'hFFFFFF80 : 32'h00000080;
      accept(s == 0 ? 4'd1 : 4'd2, 32'h0, 5'd7, 1'b1, 32'h1001, 32'h0);
      checks++; if ({bus_req, bus_we, bus_addr, bus_be} !== {1'b1, 1'b0, 32'h1000, 4'b1111}) begin errors++; $display("FAIL lb_bus got req=%b we=%b addr=%h be=%b exp req=1 we=0 addr=00001000 be=1111", bus_req, bus_we, bus_addr, bus_be); end
      for (int w = 0; w < 3; w++) begin
        checks++; if ({ex_ready, bus_req} !== 2'b01) begin errors++; $display("FAIL lb_wait got ready=%b req=%b exp ready=0 req=1", ex_ready, bus_req); end
        tick();
      end
      ack(32'hAA80CCDD);
      checks++; if ({wb_valid, wb_wdata, wb_waddr, wb_wr_en, mem_err, bus_req} !== {1'b1, exp, 5'd7, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL lb_wb got v=%b d=%h a=%0d we=%b err=%b req=%b exp d=%h", wb_valid, wb_wdata, wb_waddr, wb_wr_en, mem_err, bus_req, exp); end
      tick();
    end
  endtask

  task automatic test_store_half;
    accept(4'd7, 32'h0, 5'd9, 1'b1, 32'h2002, 32'h0000BEEF);
    checks++; if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b1, 1'b1, 32'h2000, 4'b0011, 32'hBEEFBEEF}) begin errors++; $display("FAIL sh_bus got req=%b we=%b addr=%h be=%b wdata=%h exp 1 1 00002000 0011 beefbeef", bus_req, bus_we, bus_addr, bus_be, bus_wdata); end
    ack(32'h0);
    checks++; if ({wb_valid, wb_wr_en, mem_err} !== 3'b100) begin errors++; $display("FAIL sh_wb got v=%b we=%b err=%b exp v=1 we=0 err=0", wb_valid, wb_wr_en, mem_err); end
    tick();
  endtask

  task automatic test_timeout;
    int k;
    accept(4'd5, 32'h0, 5'd4, 1'b1, 32'h400, 32'h0);
    k = 0;
    while (bus_req === 1'b1 && k < 12) begin k++; tick(); end
    checks++; if (k !== 4) begin errors++; $display("FAIL tmo_req_cycles got=%0d exp=4", k); end
    checks++; if ({mem_err, wb_valid, wb_wr_en, ex_ready} !== 4'b1101) begin errors++; $display("FAIL tmo_wb got err=%b v=%b we=%b ready=%b exp 1 1 0 1", mem_err, wb_valid, wb_wr_en, ex_ready); end
    tick();
    checks++; if ({mem_err, wb_valid} !== 2'b00) begin errors++; $display("FAIL tmo_pulse got err=%b v=%b exp 0 0", mem_err, wb_valid); end
  endtask

  task automatic test_reset_mid_access;
    accept(4'd5, 32'h0, 5'd5, 1'b1, 32'h500, 32'h0);
    tick();
    ex_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if ({bus_req, wb_valid, ex_ready} !== 3'b001) begin errors++; $display("FAIL rst_async got req=%b v=%b ready=%b exp 0 0 1", bus_req, wb_valid, ex_ready); end
    @(negedge clk);
    rst = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    tick(); tick();
    bus_ack = 1'b0;
    checks++; if ({bus_req, wb_valid} !== 2'b00) begin errors++; $display("FAIL rst_no_wb got req=%b v=%b exp 0 0", bus_req, wb_valid); end
    accept(4'd12, 32'hCAFE0001, 5'd30, 1'b1, 32'h0, 32'h0);
    checks++; if ({wb_valid, wb_wdata, wb_waddr, wb_wr_en} !== {1'b1, 32'hCAFE0001, 5'd30, 1'b1}) begin errors++; $display("FAIL rst_alu_after got v=%b d=%h a=%0d we=%b exp 1 cafe0001 30 1", wb_valid, wb_wdata, wb_waddr, wb_wr_en); end
    tick();
  endtask

  task automatic test_align;
    accept(4'd5, 32'h0, 5'd6, 1'b1, 32'h3002, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    checks++; if ({bus_req, mem_err, wb_valid, wb_wr_en} !== 4'b0110) begin errors++; $display("FAIL align_err got req=%b err=%b v=%b we=%b exp 0 1 1 0", bus_req, mem_err, wb_valid, wb_wr_en); end
    tick();
    checks++; if ({bus_req, mem_err} !== 2'b00) begin errors++; $display("FAIL align_after got req=%b err=%b exp 0 0", bus_req, mem_err); end
`else
    checks++; if ({bus_req, bus_addr, bus_be, mem_err} !== {1'b1, 32'h3000, 4'b1111, 1'b0}) begin errors++; $display("FAIL align_ignored got req=%b addr=%h be=%b err=%b exp 1 00003000 1111 0", bus_req, bus_addr, bus_be, mem_err); end
    ack(32'h01020304);
    checks++; if ({wb_valid, wb_wdata, mem_err} !== {1'b1, 32'h01020304, 1'b0}) begin errors++; $display("FAIL align_lw got v=%b d=%h err=%b exp 1 01020304 0", wb_valid, wb_wdata, mem_err); end
    tick();
`endif
  endtask

  task automatic test_back_to_back;
    accept(4'd5, 32'h0, 5'd11, 1'b1, 32'h40, 32'h0);
    ack(32'h55AA55AA);
    checks++; if ({wb_valid, ex_ready, wb_wdata} !== {1'b1, 1'b1, 32'h55AA55AA}) begin errors++; $display("FAIL b2b_first got v=%b ready=%b d=%h exp 1 1 55aa55aa", wb_valid, ex_ready, wb_wdata); end
    accept(4'd0, 32'h0BADF00D, 5'd12, 1'b1, 32'h0, 32'h0);
    checks++; if ({wb_valid, wb_wdata, wb_waddr} !== {1'b1, 32'h0BADF00D, 5'd12}) begin errors++; $display("FAIL b2b_second got v=%b d=%h a=%0d exp 1 0badf00d 12", wb_valid, wb_wdata, wb_waddr); end
    tick();
  endtask

  task automatic test_random;
    for (int n = 0; n < 80; n++) begin
      logic [3:0] op;
      logic [31:0] wd, addr, sd, rd;
      logic [4:0] wa;
      logic we, is_ld;
      int w;
      op = 4'($urandom_range(0, 15)); wd = $urandom; addr = $urandom; sd = $urandom; rd = $urandom;
      wa = 5'($urandom); we = 1'($urandom); w = $urandom_range(0, 3);
      is_ld = op >= 4'd1 && op <= 4'd5;
      accept(op, wd, wa, we, addr, sd);
      if (op == 4'd0 || op > 4'd8) begin
        checks++; if ({wb_valid, wb_wdata, wb_waddr, wb_wr_en, bus_req} !== {1'b1, wd, wa, we, 1'b0}) begin errors++; $display("FAIL rnd_alu op=%0d got v=%b d=%h a=%0d we=%b req=%b exp d=%h a=%0d we=%b", op, wb_valid, wb_wdata, wb_waddr, wb_wr_en, bus_req, wd, wa, we); end
      end else if (model_mis(op, addr)) begin
        checks++; if ({bus_req, mem_err, wb_valid, wb_wr_en} !== 4'b0110) begin errors++; $display("FAIL rnd_misalign op=%0d addr=%h got req=%b err=%b v=%b we=%b exp 0 1 1 0", op, addr, bus_req, mem_err, wb_valid, wb_wr_en); end
      end else begin
        checks++; if ({bus_req, bus_we, bus_addr, bus_be} !== {1'b1, ~is_ld, addr & 32'hFFFFFFFC, model_be(op, addr[1:0])}) begin errors++; $display("FAIL rnd_bus op=%0d addr=%h got req=%b we=%b addr=%h be=%b exp be=%b", op, addr, bus_req, bus_we, bus_addr, bus_be, model_be(op, addr[1:0])); end
        if (!is_ld) begin
          checks++; if (bus_wdata !== model_wdata(op, sd)) begin errors++; $display("FAIL rnd_wdata op=%0d sd=%h got=%h exp=%h", op, sd, bus_wdata, model_wdata(op, sd)); end
        end
        for (int i = 0; i < w; i++) tick();
        checks++; if ({bus_req, ex_ready} !== 2'b10) begin errors++; $display("FAIL rnd_hold op=%0d wait=%0d got req=%b ready=%b exp 1 0", op, w, bus_req, ex_ready); end
        ack(rd);
        checks++; if ({wb_valid, wb_waddr, wb_wr_en, mem_err, bus_req} !== {1'b1, wa, we & is_ld, 1'b0, 1'b0}) begin errors++; $display("FAIL rnd_wb op=%0d got v=%b a=%0d we=%b err=%b req=%b exp a=%0d we=%b", op, wb_valid, wb_waddr, wb_wr_en, mem_err, bus_req, wa, we & is_ld); end
        if (is_ld) begin
          checks++; if (wb_wdata !== model_load(op, addr[1:0], rd)) begin errors++; $display("FAIL rnd_load op=%0d off=%0d rd=%h got=%h exp=%h", op, addr[1:0], rd, wb_wdata, model_load(op, addr[1:0], rd)); end
        end
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_store_half();
    test_timeout();
    test_reset_mid_access();
    test_align();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
